// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } tx_state_e;

  localparam int DATA_W_DEFAULT = 8;
  localparam int STATS_W        = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage array for the transmit FIFO: one write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = DATA_W_DEFAULT,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage carries no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side FIFO and load FSM feeding the UART transmitter in the Tx_Clock domain.
// Define UART_TX_FIFO_STATS_EN to add the Tx_Count / Drop_Count statistics outputs.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = DATA_W_DEFAULT,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              Wr_En,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Full,
  output logic              Fifo_Empty,
  output logic [AW:0]       Level,
  output logic              Overflow,
  input  logic              Ovf_Clr,
  input  logic              Tx_Empty,
  output logic              Ld_Tx_Data,
  output logic [DATA_W-1:0] Tx_Data
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [STATS_W-1:0] Tx_Count,
  output logic [STATS_W-1:0] Drop_Count
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end

  localparam int          DepthInt  = DEPTH;
  localparam logic [AW:0] FullLevel = DepthInt[AW:0];

  tx_state_e         state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] rd_data;
  logic              push, drop, pop;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk_i  (Clock),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(Wr_Data),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  // Full/empty come from the registered count, so a push at Full is dropped even alongside a pop.
  assign Full       = (level_q == FullLevel);
  assign Fifo_Empty = (level_q == '0);
  assign Level      = level_q;
  assign push       = Wr_En && !Full && !Flush;
  assign drop       = Wr_En && Full && !Flush;
  assign pop        = (state_q == IDLE) && !Fifo_Empty && Tx_Empty && !Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (Ovf_Clr) begin
      ovf_d = 1'b0;
    end
  end

  // ACK holds until the transmitter shows it took the byte, which prevents a double load.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = LOAD;
          tx_data_d = rd_data;
        end
      end
      LOAD:    state_d = ACK;
      ACK:     if (!Tx_Empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign Overflow   = ovf_q;
  assign Ld_Tx_Data = (state_q == LOAD);
  assign Tx_Data    = tx_data_q;

`ifdef UART_TX_FIFO_STATS_EN
  logic [STATS_W-1:0] tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;

  // Every pop enters LOAD; the send counter wraps while the drop counter saturates.
  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pop) tx_cnt_d = tx_cnt_q + 1'b1;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Tx_Count   = tx_cnt_q;
  assign Drop_Count = drop_cnt_q;
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter and feeds it bytes.
- The host pushes bytes into a parameterised FIFO.
- A small FSM pops bytes and drives the transmitter's load strobe and data bus, and watches the transmitter's empty flag.
- Clocked by the same clock as the transmitter (Tx_Clock domain), so no synchronisers are needed.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, minimum 2
DATA_W, 8, byte width; matches the transmitter data bus
AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
Clock  input  1  transmitter clock (same net as UART Tx_Clock)
Reset_n  input  1  asynchronous, active-low reset
Flush  input  1  synchronous clear of FIFO contents
Wr_En  input  1  host push strobe
Wr_Data  input  DATA_W  host byte
Full  output  1  FIFO holds DEPTH entries
Fifo_Empty  output  1  FIFO holds 0 entries
Level  output  AW+1  current entry count, 0..DEPTH
Overflow  output  1  sticky; push attempted while Full
Ovf_Clr  input  1  clears Overflow
Tx_Empty  input  1  transmitter holding register free
Ld_Tx_Data  output  1  load strobe to transmitter
Tx_Data  output  DATA_W  byte to transmitter

Behaviour:
- Interface clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - Level=0, Fifo_Empty=1, Full=0, Overflow=0, Ld_Tx_Data=0, Tx_Data=0.
  - FSM=IDLE; read and write pointers = 0.
- Push:
  - Wr_En && !Full writes Wr_Data at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
  - Wr_En && Full drops the byte and sets Overflow; count and pointers are unchanged.
  - Full is evaluated on the registered count before any same-cycle pop, so a push at Full is dropped even if a pop occurs that cycle.
- Count:
  - Level is incremented on push, decremented on pop, and unchanged on simultaneous push+pop.
  - Full = (Level==DEPTH); Fifo_Empty = (Level==0). Both are derived from registered Level.
- FSM states:
  - IDLE:
    - If !Fifo_Empty && Tx_Empty: capture mem[rd_ptr] into Tx_Data, pop (rd_ptr+1, wrap), go to LOAD.
    - Otherwise stay.
  - LOAD:
    - Ld_Tx_Data=1 for exactly one cycle.
    - Next state is always ACK. The transmitter accepts on this edge because Tx_Empty was 1.
  - ACK:
    - Stay while Tx_Empty==1, waiting for the transmitter to register the load.
    - Go to IDLE when Tx_Empty==0.
    - This prevents a double load.
- Ld_Tx_Data = (state==LOAD), decoded from registered state with no combinational input path. Tx_Data is registered and holds its value outside LOAD.
- Latency: push sampled at edge k into an empty FIFO with Tx_Empty=1:
  - LOAD is entered at edge k+1.
  - The transmitter loads at edge k+2.
- Back-to-back bytes: the next LOAD begins one cycle after Tx_Empty returns to 1.
- Flush:
  - Clears pointers and Level and drops all queued bytes.
  - From IDLE or ACK, the FSM keeps its state.
  - From LOAD, the FSM goes to ACK; the strobe was already presented and that byte is committed.
  - Flush has priority over a same-cycle Wr_En; the push is ignored.
- Overflow:
  - Ovf_Clr clears it.
  - Simultaneous set and clear leaves it set.
- Reset mid-operation: all state returns to reset values immediately. Any queued or captured byte is lost.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- When defined, add:
  - Tx_Count output, 16-bit: increments on each LOAD entry and wraps at 0xFFFF->0.
  - Drop_Count output, 16-bit: increments on each overflow drop and saturates at 0xFFFF.
  - Both counters reset to 0 on Reset_n and are unaffected by Flush.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package uart_pkg contains:
  - State typedef (IDLE, LOAD, ACK).
  - DATA_W default constant (8).
  - Stats counter width constant (16).
- One sub-module, uart_fifo_mem: a DEPTH x DATA_W register array with one write port and one asynchronous read port. Pointers, count and FSM stay in uart_tx_fifo.

Test Plan:
- Reset, then push 0xA5 with Tx_Empty=1:
  - Ld_Tx_Data high for one cycle at edge k+1..k+2 with Tx_Data=0xA5.
  - Level goes 1 then 0.
  - FSM waits in ACK until the model drops Tx_Empty.
- Push 0x01..0x03 while the transmitter model holds Tx_Empty=0 for 20 cycles, then releases:
  - Exactly three loads occur, in order 0x01, 0x02, 0x03.
  - Each load happens only after Tx_Empty has returned to 1.
- Fill 16 entries with Tx_Empty=0, then push 0xFF:
  - Full=1, Level=16, Overflow=1, and 0xFF is never transmitted.
  - Ovf_Clr then clears Overflow.
- Pointer wrap: stream 40 bytes 0x00..0x27 with random Tx_Empty gaps and random push timing:
  - Transmitter scoreboard receives all 40 in order.
  - No double load occurs.
- Flush asserted during LOAD with 5 entries queued:
  - The in-flight byte is loaded once; the remaining 4 are discarded.
  - Level=0, FSM passes through ACK, and no further Ld_Tx_Data pulses occur.
- Assert Reset_n low mid-ACK with 3 queued:
  - All outputs return to reset values asynchronously.
  - After release, no loads occur until a new push.
